// File: rtl/fold_sequencer.sv
// Profile RAM sequencer for one fold run: CLEAR all bins, FOLD (+1 per accepted bin via 2-cycle RMW), SCAN out.
// Bin requests that find the FIFO full are dropped and counted; optional FOLD_SAT_EN saturates bin counts.
module fold_sequencer #(
  parameter int NBINS = 1024,
  parameter int AW    = 10,
  parameter int DW    = 32,
  parameter int FDEP  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [31:0]   fold_count,
  input  logic          bin_valid,
  input  logic [AW-1:0] bin_index,
  output logic          busy,
  output logic          done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          scan_valid,
  output logic [AW-1:0] scan_index,
  output logic [DW-1:0] scan_value,
  output logic          scan_last,
  output logic [15:0]   drop_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FOLD, S_SCAN, S_DONE} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NBINS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] rmw_addr_q, rmw_addr_d;
  logic [AW-1:0] scan_idx_q, scan_idx_d;
  logic [31:0]   fold_cnt_q, fold_cnt_d;
  logic [31:0]   acc_cnt_q, acc_cnt_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic          rmw_q, rmw_d;
  logic          scan_vld_q, scan_vld_d;
  logic          scan_last_q, scan_last_d;

  logic          fifo_push_vld, fifo_pop_rdy, fifo_flush;
  logic          fifo_empty, fifo_full;
  logic [AW-1:0] fifo_dat;
  logic [DW-1:0] incr_dat;

  fold_fifo #(.W(AW), .DEPTH(FDEP)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (fifo_flush),
    .push_vld (fifo_push_vld),
    .push_dat (bin_index),
    .pop_rdy  (fifo_pop_rdy),
    .pop_dat  (fifo_dat),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_comb begin
`ifdef FOLD_SAT_EN
    incr_dat = (&mem_rdata) ? mem_rdata : mem_rdata + DW'(1);
`else
    incr_dat = mem_rdata + DW'(1);
`endif
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rmw_addr_d    = rmw_addr_q;
    fold_cnt_d    = fold_cnt_q;
    acc_cnt_d     = acc_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    rmw_d         = 1'b0;
    scan_vld_d    = 1'b0;
    scan_idx_d    = '0;
    scan_last_d   = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    fifo_push_vld = 1'b0;
    fifo_pop_rdy  = 1'b0;
    fifo_flush    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CLEAR;
          fold_cnt_d = fold_count;
          acc_cnt_d  = '0;
          drop_cnt_d = '0;
          addr_d     = '0;
        end
      end
      S_CLEAR: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = addr_q;
        addr_d   = addr_q + AW'(1);
        if (addr_q == LAST_ADDR) begin
          state_d = (fold_cnt_q == '0) ? S_SCAN : S_FOLD;
        end
      end
      S_FOLD: begin
        if (bin_valid && (acc_cnt_q < fold_cnt_q)) begin
          if (fifo_full) begin
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          end else begin
            fifo_push_vld = 1'b1;
            acc_cnt_d     = acc_cnt_q + 32'd1;
          end
        end
        // Write phase blocks the next pop, so a repeated bin always reads the updated count.
        if (rmw_q) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = rmw_addr_q;
          mem_wdata = incr_dat;
        end else if (!fifo_empty) begin
          fifo_pop_rdy = 1'b1;
          mem_en       = 1'b1;
          mem_addr     = fifo_dat;
          rmw_d        = 1'b1;
          rmw_addr_d   = fifo_dat;
        end
        if ((acc_cnt_q == fold_cnt_q) && fifo_empty && !rmw_q) begin
          state_d = S_SCAN;
          addr_d  = '0;
        end
      end
      S_SCAN: begin
        if (scan_vld_q && scan_last_q) begin
          state_d = S_DONE;
        end else begin
          mem_en      = 1'b1;
          mem_addr    = addr_q;
          addr_d      = addr_q + AW'(1);
          scan_vld_d  = 1'b1;
          scan_idx_d  = addr_q;
          scan_last_d = (addr_q == LAST_ADDR);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything, including a start seen in IDLE and a write due this cycle.
    if (abort) begin
      state_d       = S_IDLE;
      addr_d        = '0;
      fold_cnt_d    = fold_cnt_q;
      acc_cnt_d     = acc_cnt_q;
      drop_cnt_d    = drop_cnt_q;
      rmw_d         = 1'b0;
      scan_vld_d    = 1'b0;
      scan_idx_d    = '0;
      scan_last_d   = 1'b0;
      mem_en        = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      fifo_push_vld = 1'b0;
      fifo_pop_rdy  = 1'b0;
      fifo_flush    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rmw_addr_q  <= '0;
      fold_cnt_q  <= '0;
      acc_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      rmw_q       <= 1'b0;
      scan_vld_q  <= 1'b0;
      scan_idx_q  <= '0;
      scan_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rmw_addr_q  <= rmw_addr_d;
      fold_cnt_q  <= fold_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      rmw_q       <= rmw_d;
      scan_vld_q  <= scan_vld_d;
      scan_idx_q  <= scan_idx_d;
      scan_last_q <= scan_last_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign scan_valid = scan_vld_q;
  assign scan_index = scan_idx_q;
  assign scan_last  = scan_last_q;
  assign scan_value = scan_vld_q ? mem_rdata : '0;
  assign drop_cnt   = drop_cnt_q;

endmodule

// Bin request FIFO: registered storage, pop data visible combinationally, no same-cycle bypass.
module fold_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat,
  output logic         empty,
  output logic         full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop_dat = mem_q[rd_q];
  assign do_push = push_vld && !full;
  assign do_pop  = pop_rdy && !empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q] = push_dat;
      wr_d        = wr_q + PW'(1);
    end
    if (do_pop) rd_d = rd_q + PW'(1);
    cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fold_sequencer.sv
// Randomized bench for fold_sequencer with a behavioural RAM, a cycle-level intake model and a scan scoreboard.
module tb_fold_sequencer;

  localparam int NBINS = 16;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int FDEP  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [31:0]   fold_count = '0;
  logic          bin_valid = 1'b0;
  logic [AW-1:0] bin_index = '0;
  logic          busy, done, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          scan_valid, scan_last;
  logic [AW-1:0] scan_index;
  logic [DW-1:0] scan_value;
  logic [15:0]   drop_cnt;

  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [DW-1:0] poke_dat = '0;
  logic [DW-1:0] ram [NBINS];

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] val;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   dir_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic prev_last = 1'b0;

  fold_sequencer #(.NBINS(NBINS), .AW(AW), .DW(DW), .FDEP(FDEP)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .fold_count (fold_count),
    .bin_valid  (bin_valid),
    .bin_index  (bin_index),
    .busy       (busy),
    .done       (done),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .scan_valid (scan_valid),
    .scan_index (scan_index),
    .scan_value (scan_value),
    .scan_last  (scan_last),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    else if (poke_en) ram[poke_addr] <= poke_dat;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] bump(input logic [DW-1:0] v);
`ifdef FOLD_SAT_EN
    return (v == {DW{1'b1}}) ? v : v + DW'(1);
`else
    return v + DW'(1);
`endif
  endfunction

  // Scan monitor: every scan beat must match the next expected bin; done must follow scan_last by one cycle.
  always @(negedge clk) begin
    if (!rst) begin
      prev_last = 1'b0;
    end else begin
      if (scan_valid) begin
        if (exp_q.size() == 0) begin
          check("scan_unexpected", 64'(scan_index), 64'hFFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("scan_index", 64'(scan_index), 64'(mon_e.idx));
          check("scan_value", 64'(scan_value), 64'(mon_e.val));
          check("scan_last", 64'(scan_last), 64'(mon_e.last));
        end
      end
      if (done || prev_last) check("done_pulse", 64'(done), 64'(prev_last));
      prev_last = scan_valid && scan_last;
    end
  end

  task automatic fill_garbage();
    for (int i = 0; i < NBINS; i++) begin
      poke_en   = 1'b1;
      poke_addr = AW'(i);
      poke_dat  = $urandom;
      @(posedge clk); #1;
    end
    poke_en = 1'b0;
  endtask

  task automatic idle_check(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(nm, {62'd0, busy, mem_en}, 64'd0);
      @(posedge clk); #1;
    end
  endtask

  // One run: start, CLEAR, FOLD under the intake model, then scoreboard the scan and the final counters.
  task automatic run_fold(input int fc, input int prob, input bit preload, input int abort_at);
    logic [DW-1:0] hist [NBINS];
    int            q[$];
    int            next_pop, acc, drops, t, b;
    bit            bv, pop, got;
    logic [AW-1:0] bi;
    exp_t          e;

    fold_count = 32'(fc);
    start      = 1'b1;
    @(negedge clk);
    check("start_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;

    for (int i = 0; i < NBINS; i++) begin
      bin_valid = 1'($urandom_range(0, 1));
      bin_index = AW'($urandom_range(0, NBINS - 1));
      @(negedge clk);
      check("clear_wr", 64'({busy, mem_en, mem_we, mem_addr, mem_wdata}),
            64'({3'b111, AW'(i), {DW{1'b0}}}));
      @(posedge clk); #1;
    end
    bin_valid = 1'b0;

    for (int i = 0; i < NBINS; i++) hist[i] = '0;
    if (preload) hist[2] = {DW{1'b1}};
    acc = 0; drops = 0; next_pop = 0; t = 0;

    if (fc > 0) begin
      while (!(acc == fc && q.size() == 0 && t >= next_pop)) begin
        if (t >= 4000) begin
          check("fold_timeout", 64'd0, 64'd1);
          break;
        end
        if (t == abort_at) begin
          abort     = 1'b1;
          bin_valid = 1'b0;
          poke_en   = 1'b0;
          @(negedge clk);
          check("abort_nowr", 64'(mem_we), 64'd0);
          @(posedge clk); #1;
          abort = 1'b0;
          @(negedge clk);
          check("abort_idle", 64'({busy, mem_en, mem_we, scan_valid}), 64'd0);
          check("abort_drop", 64'(drop_cnt), 64'(drops));
          @(posedge clk); #1;
          return;
        end
        poke_en   = preload && (t == 0);
        poke_addr = AW'(2);
        poke_dat  = {DW{1'b1}};
        if (t < dir_q.size()) begin
          bv = (dir_q[t] >= 0);
          bi = bv ? AW'(dir_q[t]) : AW'($urandom_range(0, NBINS - 1));
        end else begin
          bv = (acc < fc || $urandom_range(0, 3) == 0) && ($urandom_range(0, 99) < prob);
          bi = (preload && $urandom_range(0, 1) == 1) ? AW'(2) : AW'($urandom_range(0, NBINS - 1));
        end
        // One bin leaves the queue at most every other cycle; a full queue at cycle start drops the request.
        pop = (q.size() > 0) && (t >= next_pop);
        if (bv && acc < fc) begin
          if (q.size() == FDEP) begin
            if (drops < 65535) drops++;
          end else begin
            q.push_back(int'(bi));
            acc++;
          end
        end
        if (pop) begin
          b        = q.pop_front();
          hist[b]  = bump(hist[b]);
          next_pop = t + 2;
        end
        bin_valid = bv;
        bin_index = bi;
        @(posedge clk); #1;
        t++;
      end
    end
    bin_valid = 1'b0;
    poke_en   = 1'b0;

    for (int i = 0; i < NBINS; i++) begin
      e.idx  = AW'(i);
      e.val  = hist[i];
      e.last = (i == NBINS - 1);
      exp_q.push_back(e);
    end

    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", 64'(got), 64'd1);
    check("drop_cnt", 64'(drop_cnt), 64'(drops));
    @(negedge clk);
    check("idle_after", 64'({busy, done}), 64'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_ctrl", 64'({busy, done, mem_en, mem_we, scan_valid, scan_last, mem_addr, scan_index, drop_cnt}), 64'd0);
    check("rst_data", {mem_wdata, scan_value}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_check("idle_pre", 4);

    fill_garbage();
    dir_q.delete();
    run_fold(0, 50, 1'b0, -1);

    fill_garbage();
    dir_q = '{3, -1, 3, -1, 3, -1, 7, -1, 15};
    run_fold(5, 0, 1'b0, -1);

    fill_garbage();
    dir_q.delete();
    for (int i = 0; i < 12; i++) dir_q.push_back($urandom_range(0, NBINS - 1));
    run_fold(16, 40, 1'b0, -1);

    fill_garbage();
    dir_q = '{2};
    run_fold(3, 60, 1'b1, -1);

    for (int r = 0; r < 4; r++) begin
      fill_garbage();
      dir_q.delete();
      run_fold($urandom_range(1, 30), $urandom_range(30, 95), 1'b0, -1);
    end

    fill_garbage();
    dir_q = '{1, 2, 3, 4};
    run_fold(10, 0, 1'b0, 4);
    idle_check("idle_post_abort", 6);

    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("abort_prio", 64'(busy), 64'd0);
    @(posedge clk); #1;

    fill_garbage();
    dir_q.delete();
    run_fold(6, 70, 1'b0, -1);

    fold_count = 32'd3;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rst_mid_ctrl", 64'({busy, done, mem_en, mem_we, scan_valid, scan_last, mem_addr, scan_index, drop_cnt}), 64'd0);
    check("rst_mid_data", {mem_wdata, scan_value}, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    idle_check("idle_post_rst", 5);

    fill_garbage();
    dir_q.delete();
    run_fold(4, 80, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
